lfsr_rnd_gen: RTL and testbench
===============================

// Module: lfsr_rnd_gen
// PURPOSE
//  Pseudo-random value generator that sits directly downstream of the main controller.
//  The controller pulses start_rnd (its Start_rnd) and waits in its wait state until done_rnd
//  (its Done_rnd) goes high.
//  Internally a Galois LFSR is advanced STEPS times per request; the result is registered on rnd_out.
//  LFSR state persists across requests, so successive requests continue the same sequence.
// PARAMETERS
//  WIDTH    16        LFSR and rnd_out width (>=4)
//  SEED     16'hACE1  reset/reload value; must be nonzero
//  TAPS     16'hB400  Galois feedback mask (x^16+x^14+x^13+x^11+1, maximal length)
//  STEPS    2         LFSR shifts per request (>=1)
//  MAX_VAL  16'h3FFF  acceptance bound; used only with RND_RANGE_EN
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous, active-high reset
//  start_rnd  in   1      request pulse; sampled only in IDLE
//  seed_load  in   1      in IDLE: load lfsr from seed_in
//  seed_in    in   WIDTH  new seed; 0 is replaced by SEED
//  done_rnd   out  1      one-cycle pulse; rnd_out is valid in this cycle
//  busy       out  1      high in SHIFT and DONE
//  rnd_out    out  WIDTH  last accepted value; held until the next done_rnd
// BEHAVIOUR
//  Reset (rst=1 at an edge): state=IDLE, lfsr=SEED, rnd_out=0, done_rnd=0, busy=0, step count=0.
//   Reset takes effect from any state, including mid-request; the aborted request produces no done_rnd.
//  Shift step: lsb=lfsr[0]; lfsr=lfsr>>1; if lsb, lfsr^=TAPS.
//  Step counter width is $clog2(STEPS+1); it counts 0..STEPS-1 with no wrap.
//  FSM states: IDLE, SHIFT, DONE.
//   IDLE:  start_rnd=1 -> SHIFT, cnt=0.
//          Else if seed_load=1, lfsr<=(seed_in==0 ? SEED : seed_in).
//          start_rnd and seed_load high together: start wins, seed is not loaded.
//   SHIFT: one shift per cycle, cnt++. After the STEPS-th shift -> DONE and rnd_out<=shifted value.
//   DONE:  done_rnd=1 for exactly this cycle -> IDLE unconditionally.
//  start_rnd or seed_load in SHIFT or DONE: ignored, not queued.
//  Latency: start sampled at edge t; done_rnd high in the cycle after edge t+STEPS (STEPS+1 cycles).
//  Back-to-back requests: earliest next start is sampled in IDLE, one cycle after DONE.
//  lfsr can never reach 0. Defensive rule: if lfsr==0 at any edge, reload SEED.
// CONFIGURATION
//  RND_RANGE_EN defined:
//   - At the STEPS-th shift, a result > MAX_VAL is rejected and the FSM stays in SHIFT.
//   - It keeps shifting one value per cycle until a value <= MAX_VAL is produced, then goes to DONE.
//   - Latency = STEPS+1+rejections.
//   - rnd_out is never > MAX_VAL.
//  RND_RANGE_EN undefined:
//   - No range check; MAX_VAL is unused.
//   - Latency is fixed at STEPS+1.
// TESTING
//  1 Reset then idle 5 cycles -> done_rnd=0, busy=0, rnd_out=0000.
//  2 Defaults; pulse start_rnd -> busy for 3 cycles; done_rnd on the 3rd cycle after start;
//    rnd_out=7138 (ACE1->E270->7138).
//  3 Second request after test 2 -> rnd_out=1C4E (389C->1C4E).
//    start_rnd held high during the request -> no extra request is taken while busy.
//  4 seed_load with seed_in=0000, then start -> same result as test 2 (7138).
//    Pulse start mid-SHIFT together with seed_load -> both ignored.
//  5 rst asserted in the SHIFT cycle -> no done_rnd; lfsr=ACE1.
//    Next request yields 7138.
//  6 RND_RANGE_EN, MAX_VAL=3FFF, reset, start -> 7138 rejected; done_rnd 4 cycles after start;
//    rnd_out=389C.

Source files
------------

// File: rtl/lfsr_rnd_gen_if.sv
// Request/response bundle between the main controller and lfsr_rnd_gen.
//   master (controller): drives start_rnd, seed_load, seed_in; observes done_rnd, busy, rnd_out
//   slave  (generator) : the reverse
// WIDTH must match the generator's WIDTH.
interface lfsr_rnd_gen_if #(
  parameter int WIDTH = 16
);
  logic             start_rnd;
  logic             seed_load;
  logic [WIDTH-1:0] seed_in;
  logic             done_rnd;
  logic             busy;
  logic [WIDTH-1:0] rnd_out;

  modport master (
    output start_rnd, seed_load, seed_in,
    input  done_rnd, busy, rnd_out
  );

  modport slave (
    input  start_rnd, seed_load, seed_in,
    output done_rnd, busy, rnd_out
  );
endinterface

// File: rtl/lfsr_rnd_gen.sv
// Pseudo-random value generator sitting behind the main controller.
// Each start_rnd request advances a Galois LFSR STEPS times and registers the
// result on rnd_out, pulsing done_rnd for one cycle. LFSR state persists
// across requests so successive requests continue one sequence.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous, active-high reset
//   bus  - lfsr_rnd_gen_if.slave:
//            start_rnd  request pulse, sampled only in IDLE
//            seed_load  in IDLE, load lfsr from seed_in (0 -> SEED)
//            seed_in    new seed
//            done_rnd   one-cycle pulse, rnd_out valid
//            busy       high in SHIFT and DONE
//            rnd_out    last accepted value, held until next done_rnd
//
// Optional feature macro: RND_RANGE_EN
//   When defined, a result > MAX_VAL at the final shift is rejected and the
//   FSM keeps shifting one value per cycle until a value <= MAX_VAL appears.
//   When undefined, latency is fixed at STEPS+1 and MAX_VAL has no effect.
module lfsr_rnd_gen #(
  parameter int               WIDTH   = 16,
  parameter logic [WIDTH-1:0] SEED    = 16'hACE1,
  parameter logic [WIDTH-1:0] TAPS    = 16'hB400,
  parameter int               STEPS   = 2,
  parameter logic [WIDTH-1:0] MAX_VAL = 16'h3FFF
) (
  input  logic                clk,
  input  logic                rst,
  lfsr_rnd_gen_if.slave       bus
);

  localparam int CW = $clog2(STEPS + 1);
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

`ifdef RND_RANGE_EN
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] lfsr;
  logic [WIDTH-1:0] lfsr_nxt;
  logic [WIDTH-1:0] rnd_q;
  logic [CW-1:0]    cnt;
  logic             accept;

  // Galois step: shift right, fold the taps in when a 1 falls out.
  assign lfsr_nxt = (lfsr >> 1) ^ (lfsr[0] ? TAPS : '0);

  // With the range check disabled every final value is accepted; the compare
  // is then constant-folded away.
  assign accept = !RANGE_EN || (lfsr_nxt <= MAX_VAL);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      lfsr  <= SEED;
      rnd_q <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          // start has priority; a simultaneous seed_load is dropped
          if (bus.start_rnd) begin
            state <= SHIFT;
            cnt   <= '0;
          end else if (bus.seed_load) begin
            lfsr <= (bus.seed_in == '0) ? SEED : bus.seed_in;
          end
        end
        SHIFT: begin
          lfsr <= lfsr_nxt;
          // cnt saturates at LAST so rejected values keep being re-checked
          if (cnt == LAST) begin
            if (accept) begin
              state <= DONE;
              rnd_q <= lfsr_nxt;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
      // all-zero is a lock-up state; recover rather than trust it can't occur
      if (lfsr == '0) lfsr <= SEED;
    end
  end

  assign bus.done_rnd = (state == DONE);
  assign bus.busy     = (state == SHIFT) || (state == DONE);
  assign bus.rnd_out  = rnd_q;

endmodule

// File: tb/tb_lfsr_rnd_gen.sv
module tb_lfsr_rnd_gen;
  localparam int          W       = 16;
  localparam logic [15:0] SEED    = 16'hACE1;
  localparam logic [15:0] TAPS    = 16'hB400;
  localparam logic [15:0] MAX_VAL = 16'h3FFF;
  localparam int          STEPS   = 2;
`ifdef RND_RANGE_EN
  localparam bit RANGE = 1'b1;
`else
  localparam bit RANGE = 1'b0;
`endif
  // first two results after reset/SEED: ACE1->E270->7138->389C->1C4E->0E27
  localparam logic [15:0] FIRST  = RANGE ? 16'h389C : 16'h7138;
  localparam logic [15:0] SECOND = RANGE ? 16'h0E27 : 16'h1C4E;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lfsr_rnd_gen_if #(.WIDTH(W)) bus();

  lfsr_rnd_gen #(
    .WIDTH(W), .SEED(SEED), .TAPS(TAPS), .STEPS(STEPS), .MAX_VAL(MAX_VAL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] model_lfsr;
  logic [15:0] exp_q[$];
  int          lat_q[$];

  function automatic logic [15:0] step(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? TAPS : 16'h0000);
  endfunction

  // push expected value and latency for one accepted request
  task automatic model_push();
    logic [15:0] v;
    int n;
    v = model_lfsr;
    n = 0;
    for (int i = 0; i < STEPS; i++) begin
      v = step(v);
      n++;
    end
    while (RANGE && v > MAX_VAL) begin
      v = step(v);
      n++;
    end
    model_lfsr = v;
    exp_q.push_back(v);
    lat_q.push_back(n + 1);
  endtask

  // drive one request, wait (bounded) for done_rnd, pop the scoreboard
  task automatic run_req(input bit hold, input bit with_seed, input logic [15:0] sv,
                         output logic [15:0] got, output logic [15:0] exp,
                         output int lat, output int exp_lat, output int busy_cnt);
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    bus.start_rnd = 1'b1;
    if (with_seed) begin
      bus.seed_load = 1'b1;
      bus.seed_in   = sv;
    end
    model_push();
    lat = 0;
    busy_cnt = 0;
    got = 16'h0000;
    while (!seen && lat < 64) begin
      @(negedge clk);
      lat++;
      if (!hold) bus.start_rnd = 1'b0;
      bus.seed_load = 1'b0;
      if (bus.busy) busy_cnt++;
      if (bus.done_rnd) begin
        seen = 1'b1;
        got  = bus.rnd_out;
      end
    end
    bus.start_rnd = 1'b0;
    if (!seen) lat = -1;
    exp     = exp_q.pop_front();
    exp_lat = lat_q.pop_front();
  endtask

  task automatic test_reset();
    bus.start_rnd = 1'b0;
    bus.seed_load = 1'b0;
    bus.seed_in   = 16'h0000;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_lfsr = SEED;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if ({bus.done_rnd, bus.busy} !== 2'b00) begin
        miscompares++;
        $display("FAIL reset_idle cycle %0d: done/busy=%b required 00", i, {bus.done_rnd, bus.busy});
      end
    end
    vectors++;
    if (bus.rnd_out !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_rnd_out: got %h required 0000", bus.rnd_out);
    end
  endtask

  task automatic test_basic();
    logic [15:0] got, exp;
    int lat, exp_lat, bc;
    run_req(1'b0, 1'b0, 16'h0, got, exp, lat, exp_lat, bc);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL basic_model: got %h required %h", got, exp);
    end
    vectors++;
    if (got !== FIRST) begin
      miscompares++;
      $display("FAIL basic_const: got %h required %h", got, FIRST);
    end
    vectors++;
    if (lat !== exp_lat) begin
      miscompares++;
      $display("FAIL basic_latency: got %0d required %0d", lat, exp_lat);
    end
    vectors++;
    if (bc !== exp_lat) begin
      miscompares++;
      $display("FAIL basic_busy_cycles: got %0d required %0d", bc, exp_lat);
    end
    @(negedge clk);
    vectors++;
    if ({bus.done_rnd, bus.busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL basic_done_pulse: done/busy=%b required 00", {bus.done_rnd, bus.busy});
    end
  endtask

  task automatic test_hold_start();
    logic [15:0] got, exp;
    int lat, exp_lat, bc;
    bit extra;
    run_req(1'b1, 1'b0, 16'h0, got, exp, lat, exp_lat, bc);
    vectors++;
    if (got !== SECOND || got !== exp) begin
      miscompares++;
      $display("FAIL hold_value: got %h required %h", got, SECOND);
    end
    vectors++;
    if (lat !== exp_lat) begin
      miscompares++;
      $display("FAIL hold_latency: got %0d required %0d", lat, exp_lat);
    end
    extra = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (bus.done_rnd || bus.busy) extra = 1'b1;
    end
    vectors++;
    if (extra !== 1'b0) begin
      miscompares++;
      $display("FAIL hold_no_extra_request: activity=%b required 0", extra);
    end
  endtask

  task automatic test_seed_load();
    logic [15:0] got, exp;
    int lat, exp_lat, bc;
    bit seen;
    // seed 0 means "use SEED"
    @(negedge clk);
    bus.seed_load = 1'b1;
    bus.seed_in   = 16'h0000;
    @(negedge clk);
    bus.seed_load = 1'b0;
    model_lfsr = SEED;
    run_req(1'b0, 1'b0, 16'h0, got, exp, lat, exp_lat, bc);
    vectors++;
    if (got !== FIRST) begin
      miscompares++;
      $display("FAIL seed_zero: got %h required %h", got, FIRST);
    end
    // start+seed_load pulsed mid-SHIFT must be ignored
    @(negedge clk);
    bus.start_rnd = 1'b1;
    model_push();
    lat = 0;
    seen = 1'b0;
    got = 16'h0000;
    while (!seen && lat < 64) begin
      @(negedge clk);
      lat++;
      bus.start_rnd = (lat == 1);
      bus.seed_load = (lat == 1);
      bus.seed_in   = 16'h1234;
      if (bus.done_rnd) begin
        seen = 1'b1;
        got  = bus.rnd_out;
      end
    end
    bus.start_rnd = 1'b0;
    bus.seed_load = 1'b0;
    exp = exp_q.pop_front();
    exp_lat = lat_q.pop_front();
    if (!seen) lat = -1;
    vectors++;
    if (got !== exp || lat !== exp_lat) begin
      miscompares++;
      $display("FAIL seed_mid_shift: got %h/%0d required %h/%0d", got, lat, exp, exp_lat);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_shift_not_queued: busy=%b required 0", bus.busy);
    end
    // start and seed_load together in IDLE: start wins, no load
    run_req(1'b0, 1'b1, 16'h1234, got, exp, lat, exp_lat, bc);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL start_beats_seed: got %h required %h", got, exp);
    end
    // plain seed load of a nonzero value
    @(negedge clk);
    bus.seed_load = 1'b1;
    bus.seed_in   = 16'h0001;
    @(negedge clk);
    bus.seed_load = 1'b0;
    model_lfsr = 16'h0001;
    run_req(1'b0, 1'b0, 16'h0, got, exp, lat, exp_lat, bc);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL seed_nonzero: got %h required %h", got, exp);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] got, exp;
    int lat, exp_lat, bc;
    bit act;
    @(negedge clk);
    bus.start_rnd = 1'b1;
    @(negedge clk);
    bus.start_rnd = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_lfsr = SEED;
    act = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus.done_rnd || bus.busy) act = 1'b1;
    end
    vectors++;
    if (act !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_abort: activity=%b required 0", act);
    end
    vectors++;
    if (bus.rnd_out !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_mid_rnd_out: got %h required 0000", bus.rnd_out);
    end
    run_req(1'b0, 1'b0, 16'h0, got, exp, lat, exp_lat, bc);
    vectors++;
    if (got !== FIRST || lat !== exp_lat) begin
      miscompares++;
      $display("FAIL reset_mid_next: got %h/%0d required %h/%0d", got, lat, FIRST, exp_lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] got [2];
    int at [2];
    int n, cyc, l1, l2;
    logic [15:0] e1, e2;
    @(negedge clk);
    bus.start_rnd = 1'b1;
    model_push();
    model_push();
    n = 0;
    cyc = 0;
    at[0] = -1;
    at[1] = -1;
    got[0] = 16'h0000;
    got[1] = 16'h0000;
    while (n < 2 && cyc < 128) begin
      @(negedge clk);
      cyc++;
      if (bus.done_rnd) begin
        got[n] = bus.rnd_out;
        at[n]  = cyc;
        n++;
      end
    end
    bus.start_rnd = 1'b0;
    e1 = exp_q.pop_front();
    e2 = exp_q.pop_front();
    l1 = lat_q.pop_front();
    l2 = lat_q.pop_front();
    vectors++;
    if (got[0] !== e1 || at[0] !== l1) begin
      miscompares++;
      $display("FAIL b2b_first: got %h@%0d required %h@%0d", got[0], at[0], e1, l1);
    end
    vectors++;
    if (got[1] !== e2 || at[1] !== l1 + 1 + l2) begin
      miscompares++;
      $display("FAIL b2b_second: got %h@%0d required %h@%0d", got[1], at[1], e2, l1 + 1 + l2);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold_start();
    test_seed_load();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
